// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction-fetch unit.
package ifu_pkg;

    // Canonical NOP (addi x0, x0, 0) presented when no instruction is valid.
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
    localparam int unsigned IFU_DEPTH    = 2;

    // One fetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    // Word-align a byte address by clearing the two low bits.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    // A redirect target is misaligned when it does not name a whole word.
    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush, occupancy count and full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_MAX);
    assign count = cnt;
    assign rdata = mem[rptr];

    // Flush wins over both operations; a push into a full FIFO is allowed only
    // when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction-fetch unit: owns the fetch PC, issues word requests to
// instruction memory, buffers returned words and presents them to ID as a
// valid/ready stream. Branch redirects from ID flush the buffer and cause
// responses still in flight for the old path to be discarded.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int unsigned DEPTH    = IFU_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        misalign_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fpc;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_d;
    logic          started;
    logic          misalign_q;

    // PC queue: one entry per outstanding request, so its count is the
    // number of requests in flight.
    logic [31:0]   pcq_head;
    logic [CW-1:0] inflight;
    logic          pcq_full;
    logic          pcq_empty;

    // Output buffer of correct-path {pc, inst} pairs.
    fetch_t        obuf_head;
    fetch_t        obuf_wdata;
    logic [CW-1:0] obuf_count;
    logic          obuf_full;
    logic          obuf_empty;

    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          issue;
    logic          rsp_take;
    logic          rsp_keep;
    logic          out_pop;

    // Credit rule: every in-flight request already owns a buffer slot, so a
    // returning word can never find the buffer full.
    assign occupancy = {1'b0, inflight} + {1'b0, obuf_count};
    assign credit_ok = occupancy < DEPTH_W;

    // The full flags are implied by the credit rule; they are kept in the
    // term so neither queue can overrun even if the credit maths changes.
    assign imem_req  = started && !redirect_valid && credit_ok && !pcq_full && !obuf_full;
    assign imem_addr = fpc;
    assign issue     = imem_req && imem_gnt;

    // A response is only meaningful while something is outstanding; stray
    // responses right after reset are ignored.
    assign rsp_take = imem_rvalid && !pcq_empty;
    assign rsp_keep = rsp_take && !redirect_valid && (discard == '0);

    assign obuf_wdata = '{pc: pcq_head, inst: imem_rdata};

    assign if_valid     = !obuf_empty;
    assign if_pc        = if_valid ? obuf_head.pc : 32'h0;
    assign if_inst      = if_valid ? obuf_head.inst : INST_NOP;
    assign out_pop      = if_valid && id_ready;
    assign misalign_err = misalign_q;

    // Discard count: on a redirect everything still outstanding after this
    // cycle belongs to the old path; the response arriving now is dropped
    // directly and so is not counted again.
    always_comb begin
        discard_d = discard;
        if (redirect_valid) begin
            discard_d = inflight - (rsp_take ? CNT_ONE : '0);
        end else if (rsp_take && (discard != '0)) begin
            discard_d = discard - CNT_ONE;
        end
    end

    // Fetch PC, discard counter, start-up gate and misalignment pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc        <= RESET_PC;
            discard    <= '0;
            started    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            started    <= 1'b1;
            discard    <= discard_d;
            misalign_q <= redirect_valid && is_misaligned(redirect_pc);
            if (redirect_valid) begin
                fpc <= align_pc(redirect_pc);
            end else if (issue) begin
                fpc <= fpc + 32'd4;
            end
        end
    end

    ifu_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (issue),
        .wdata (fpc),
        .pop   (rsp_take),
        .flush (1'b0),
        .rdata (pcq_head),
        .count (inflight),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    ifu_fifo #(
        .WIDTH ($bits(fetch_t)),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_keep),
        .wdata (obuf_wdata),
        .pop   (out_pop),
        .flush (redirect_valid),
        .rdata (obuf_head),
        .count (obuf_count),
        .full  (obuf_full),
        .empty (obuf_empty)
    );

endmodule

// File: tb/tb_ifu.sv
// Randomised scoreboard bench for ifu. A memory model serves requests in
// order; the expected instruction stream is the sequential word stream from
// the most recent fetch target, rebuilt whenever a redirect is driven.
module tb_ifu;
    import ifu_pkg::*;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        misalign_err;

    ifu #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int handshakes = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int unsigned stamp;
    } pend_t;

    pend_t       pend_q[$];   // requests accepted by memory, not yet answered
    logic [31:0] exp_q[$];    // PCs ID should receive, in order
    logic [31:0] exp_fetch = RST_PC;
    bit          prev_mis = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    // Memory contents: an address-dependent scramble so every word differs.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_path(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(start + 32'(i * 4));
        end
    endtask

    // One clock of stimulus, driven just after the rising edge.
    task automatic cycle(input bit gnt, input bit rsp, input bit rdy, input bit redir,
                         input logic [31:0] tgt);
        @(posedge clk);
        #1;
        cyc++;
        imem_gnt = gnt;
        id_ready = rdy;
        if (rsp && pend_q.size() > 0 && pend_q[0].stamp < cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0].addr);
            pend_q.delete(0);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        redirect_valid = redir;
        redirect_pc    = redir ? tgt : $urandom;
        if (redir) begin
            // The head handed over in the redirect cycle belongs to ID.
            bit          keep = if_valid && rdy && (exp_q.size() > 0);
            logic [31:0] head = keep ? exp_q[0] : 32'h0;
            load_path({tgt[31:2], 2'b00});
            if (keep) exp_q.push_front(head);
        end
    endtask

    task automatic idle_inputs();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
    endtask

    // Monitor: protocol and stream checks on every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_imem_req", 32'(imem_req), 32'd0);
            check("rst_if_valid", 32'(if_valid), 32'd0);
            check("rst_if_pc", if_pc, 32'h0);
            check("rst_if_inst", if_inst, INST_NOP);
            check("rst_misalign", 32'(misalign_err), 32'd0);
            pend_q.delete();
            prev_mis   = 1'b0;
            prev_stall = 1'b0;
            exp_fetch  = RST_PC;
        end else begin
            check("misalign_err", 32'(misalign_err), 32'(prev_mis));
            prev_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (!if_valid) check("idle_inst_nop", if_inst, INST_NOP);
            if (if_valid && id_ready) begin
                handshakes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream: unexpected if_pc %h, expected nothing", if_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e);
                    check("if_inst", if_inst, mem_word(e));
                end
            end
            check("credit", 32'((pend_q.size() + (imem_rvalid ? 1 : 0)) <= DEPTH), 32'd1);
            if (redirect_valid) check("req_in_redirect", 32'(imem_req), 32'd0);
            if (prev_stall && !redirect_valid) begin
                check("req_hold", 32'(imem_req), 32'd1);
                check("addr_hold", imem_addr, prev_addr);
            end
            prev_stall = imem_req && !imem_gnt;
            prev_addr  = imem_addr;
            if (imem_req && imem_gnt) begin
                check("imem_addr", imem_addr, exp_fetch);
                pend_q.push_back('{addr: imem_addr, stamp: cyc});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (redirect_valid) exp_fetch = {redirect_pc[31:2], 2'b00};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit found;
        int stall_left;
        int since_redir;

        // Reset and first-word latency with an always-granting, 1-cycle memory.
        rst_n = 1'b0;
        idle_inputs();
        load_path(RST_PC);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        lat = 0;
        found = 1'b0;
        for (int k = 1; k <= 8 && !found; k++) begin
            cycle(1, 1, 1, 0, 32'h0);
            @(negedge clk);
            if (if_valid) begin
                found = 1'b1;
                lat = k;
            end
        end
        check("first_valid_latency", 32'(lat), 32'd3);
        repeat (10) cycle(1, 1, 1, 0, 32'h0);

        // ID stalls for 10 cycles: fetch must stop once the buffer is full.
        repeat (10) cycle(1, 1, 0, 0, 32'h0);
        @(negedge clk);
        check("stall_req_drop", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(if_valid), 32'd1);
        repeat (10) cycle(1, 1, 1, 0, 32'h0);

        // Two requests in flight, redirect to 0x100: both old words dropped.
        repeat (5) cycle(0, 1, 1, 0, 32'h0);
        repeat (3) cycle(1, 0, 1, 0, 32'h0);
        @(negedge clk);
        check("two_inflight", 32'(pend_q.size()), 32'd2);
        cycle(0, 1, 1, 1, 32'h0000_0100);
        repeat (3) cycle(0, 1, 1, 0, 32'h0);
        repeat (8) cycle(1, 1, 1, 0, 32'h0);

        // Redirect in the cycle a word returns while ID is stalled.
        repeat (5) cycle(0, 1, 1, 0, 32'h0);
        repeat (3) cycle(1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 32'h0);
        cycle(0, 1, 0, 1, 32'h0000_0200);
        cycle(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        check("flush_empty", 32'(if_valid), 32'd0);
        repeat (6) cycle(1, 1, 1, 0, 32'h0);

        // Misaligned redirect: fetch from 0x100, one-cycle error pulse.
        cycle(0, 1, 1, 1, 32'h0000_0102);
        cycle(1, 1, 1, 0, 32'h0);
        @(negedge clk);
        check("misalign_pulse", 32'(misalign_err), 32'd1);
        check("misalign_addr", imem_addr, 32'h0000_0100);
        cycle(1, 1, 1, 0, 32'h0);
        @(negedge clk);
        check("misalign_clear", 32'(misalign_err), 32'd0);
        repeat (6) cycle(1, 1, 1, 0, 32'h0);

        // Fetch PC wraps past the top of the address space.
        cycle(0, 1, 1, 1, 32'hFFFF_FFF8);
        repeat (10) cycle(1, 1, 1, 0, 32'h0);

        // Randomised traffic with stall bursts and frequent redirects.
        stall_left = 0;
        since_redir = 0;
        for (int n = 0; n < 3000; n++) begin
            bit rdy;
            bit redir;
            logic [31:0] tgt;
            if (stall_left > 0) begin
                stall_left--;
                rdy = 1'b0;
            end else begin
                rdy = $urandom_range(0, 99) < 80;
                if ($urandom_range(0, 99) < 3) stall_left = $urandom_range(3, 12);
            end
            redir = ($urandom_range(0, 99) < 6) || (since_redir > 80);
            since_redir = redir ? 0 : since_redir + 1;
            case ($urandom_range(0, 5))
                0:       tgt = 32'h0000_0100;
                1:       tgt = 32'h0000_0102;
                2:       tgt = 32'hFFFF_FFF8;
                3:       tgt = $urandom & 32'hFFFF_FFFC;
                default: tgt = $urandom;
            endcase
            cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75, rdy, redir, tgt);
        end

        // Reset asserted mid-burst: outputs must clear immediately.
        repeat (6) cycle(1, 1, 1, 0, 32'h0);
        repeat (2) cycle(1, 1, 0, 0, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_if_valid", 32'(if_valid), 32'd0);
        check("midrst_if_inst", if_inst, INST_NOP);
        check("midrst_imem_req", 32'(imem_req), 32'd0);
        idle_inputs();
        load_path(RST_PC);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 80, 1'b0, 32'h0);
        end
        @(negedge clk);
        check("progress", 32'(handshakes > 500), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
